// File: rtl/msd_seq_pkg.sv
// Shared state encoding and default sizing for the MSD front-end readout sequencer.
package msd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    SHIFTIN,
    FECLK,
    SETTLE,
    CONV,
    WRITE,
    DRST
  } seq_state_t;

  localparam int DEF_TOTAL_ADCS   = 10;
  localparam int DEF_CHANNELS     = 64;
  localparam int DEF_ADC_BITS     = 16;
  localparam int DEF_HOLD_TICKS   = 4;
  localparam int DEF_SETTLE_TICKS = 2;

  // Largest of three sizing values; used to size the shared tick counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/msd_readout_seq_if.sv
// Per-lane sample FIFO write bus between the readout sequencer and the ADC sample FIFOs.
interface msd_readout_seq_if
  import msd_seq_pkg::*;
#(
  parameter int TotalAdcs = DEF_TOTAL_ADCS,
  parameter int AdcBits   = DEF_ADC_BITS
) ();

  logic [TotalAdcs-1:0][AdcBits-1:0] fifoData;
  logic [TotalAdcs-1:0]              fifoWr;
  logic [TotalAdcs-1:0]              fifoFull;

  modport master (
    output fifoData,
    output fifoWr,
    input  fifoFull
  );

  modport slave (
    input  fifoData,
    input  fifoWr,
    output fifoFull
  );

endinterface

// File: rtl/msd_adc_deser.sv
// One ADC lane: AdcBits-wide MSB-first serial-to-parallel shift register.
module msd_adc_deser
  import msd_seq_pkg::*;
#(
  parameter int AdcBits = DEF_ADC_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap,
  input  logic               sdata,
  output logic [AdcBits-1:0] word
);

  // Shift in one bit per capture; the first bit of a conversion ends up as the MSB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word <= '0;
    end else if (cap) begin
      word <= {word[AdcBits-2:0], sdata};
    end
  end

endmodule

// File: rtl/msd_readout_seq.sv
// MSD front-end readout sequencer: hold, token shift-in, per-channel FE clock,
// settle, parallel serial ADC conversion and one FIFO write per lane per channel.
// Optional build macro MSD_TESTON_EN adds the testMode input driving TestOn.
module msd_readout_seq
  import msd_seq_pkg::*;
#(
  parameter int TotalAdcs   = DEF_TOTAL_ADCS,
  parameter int Channels    = DEF_CHANNELS,
  parameter int AdcBits     = DEF_ADC_BITS,
  parameter int HoldTicks   = DEF_HOLD_TICKS,
  parameter int SettleTicks = DEF_SETTLE_TICKS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic                 slwEn,
  input  logic [2:0]           gain,
`ifdef MSD_TESTON_EN
  input  logic                 testMode,
`endif
  output logic                 busy,
  output logic                 error,
  output logic                 reset,
  output logic                 compl,
  output logic                 G0,
  output logic                 G1,
  output logic                 G2,
  output logic                 Holdn,
  output logic                 DRst,
  output logic                 ShiftInn,
  output logic                 Clk,
  output logic                 TestOn,
  input  logic                 ShiftOutn,
  output logic                 SClk,
  output logic                 CsN,
  input  logic [TotalAdcs-1:0] SData,
  msd_readout_seq_if.master    fifo
);

  localparam int CHAN_W = $clog2(Channels + 1);
  localparam int TCNT_W = $clog2(max3(HoldTicks, SettleTicks, 2 * AdcBits) + 1);

  localparam logic [TCNT_W-1:0] HOLD_LAST   = TCNT_W'(HoldTicks - 1);
  localparam logic [TCNT_W-1:0] SETTLE_LAST = TCNT_W'(SettleTicks - 1);
  localparam logic [TCNT_W-1:0] CONV_LAST   = TCNT_W'(2 * AdcBits - 1);
  localparam logic [TCNT_W-1:0] DRST_COMPL  = TCNT_W'(2);
  localparam logic [CHAN_W-1:0] CHAN_LAST   = CHAN_W'(Channels - 1);

  seq_state_t        state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic              err_q, err_d;
  logic [2:0]        gain_q, gain_d;
`ifdef MSD_TESTON_EN
  logic              tm_q, tm_d;
`endif

  logic                              cap;
  logic                              abort;
  logic [TotalAdcs-1:0][AdcBits-1:0] words;

  // The FE token output is observed on the board only; it never steers the sequence.
  logic unused_shiftoutn;
  assign unused_shiftoutn = ShiftOutn;

  // Sequencer state, shared tick/phase counter, channel index and latched run settings.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      chan_q  <= '0;
      err_q   <= 1'b0;
      gain_q  <= '0;
`ifdef MSD_TESTON_EN
      tm_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      chan_q  <= chan_d;
      err_q   <= err_d;
      gain_q  <= gain_d;
`ifdef MSD_TESTON_EN
      tm_q    <= tm_d;
`endif
    end
  end

  // Next-state and pin decode; every pin step advances only on slwEn except WRITE and compl.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    chan_d      = chan_q;
    err_d       = err_q;
    gain_d      = gain_q;
`ifdef MSD_TESTON_EN
    tm_d        = tm_q;
`endif
    cap         = 1'b0;
    Holdn       = 1'b1;
    DRst        = 1'b0;
    reset       = 1'b0;
    ShiftInn    = 1'b1;
    Clk         = 1'b0;
    SClk        = 1'b1;
    CsN         = 1'b1;
    compl       = 1'b0;
    fifo.fifoWr = '0;

    unique case (state_q)
      IDLE: begin
        if (start && en) begin
          if (err_q) begin
            // A start while errored only re-arms; it does not launch a readout.
            err_d = 1'b0;
          end else begin
            state_d = HOLD;
            tcnt_d  = '0;
            chan_d  = '0;
            gain_d  = gain;
`ifdef MSD_TESTON_EN
            tm_d    = testMode;
`endif
          end
        end
      end

      HOLD: begin
        Holdn = 1'b0;
        if (slwEn) begin
          if (tcnt_q == HOLD_LAST) begin
            state_d = SHIFTIN;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end

      SHIFTIN: begin
        Holdn    = 1'b0;
        ShiftInn = 1'b0;
        Clk      = (tcnt_q == '0);
        if (slwEn) begin
          if (tcnt_q == '0) begin
            tcnt_d = TCNT_W'(1);
          end else begin
            state_d = SETTLE;
            tcnt_d  = '0;
            chan_d  = '0;
          end
        end
      end

      FECLK: begin
        Holdn = 1'b0;
        Clk   = (tcnt_q == '0);
        if (slwEn) begin
          if (tcnt_q == '0) begin
            tcnt_d = TCNT_W'(1);
          end else begin
            state_d = SETTLE;
            tcnt_d  = '0;
          end
        end
      end

      SETTLE: begin
        Holdn = 1'b0;
        if (slwEn) begin
          if (tcnt_q == SETTLE_LAST) begin
            state_d = CONV;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end

      CONV: begin
        // Even phases hold SClk high; the tick leaving an even phase is the falling edge.
        Holdn = 1'b0;
        CsN   = 1'b0;
        SClk  = ~tcnt_q[0];
        if (slwEn) begin
          cap = ~tcnt_q[0];
          if (tcnt_q == CONV_LAST) begin
            state_d = WRITE;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end

      WRITE: begin
        Holdn  = 1'b0;
        tcnt_d = '0;
        if (|fifo.fifoFull) begin
          err_d   = 1'b1;
          state_d = DRST;
        end else begin
          fifo.fifoWr = '1;
          chan_d      = chan_q + CHAN_W'(1);
          state_d     = (chan_q == CHAN_LAST) ? DRST : FECLK;
        end
      end

      DRST: begin
        if (tcnt_q == '0) begin
          Holdn = 1'b0;
          DRst  = 1'b1;
          reset = 1'b1;
        end
        if (tcnt_q == DRST_COMPL) begin
          compl   = 1'b1;
          state_d = IDLE;
          tcnt_d  = '0;
        end else if (slwEn) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase

    // Losing enable mid-run releases the FE and ADC on the next tick via DRST.
    abort = slwEn && !en && (state_q inside {HOLD, SHIFTIN, FECLK, SETTLE, CONV});
    if (abort) begin
      state_d = DRST;
      tcnt_d  = '0;
      cap     = 1'b0;
    end
  end

  assign busy          = (state_q != IDLE);
  assign error         = err_q;
  assign {G2, G1, G0}  = gain_q;
  assign fifo.fifoData = words;

`ifdef MSD_TESTON_EN
  assign TestOn = tm_q && (state_q != IDLE);
`else
  assign TestOn = 1'b0;
`endif

  for (genvar i = 0; i < TotalAdcs; i++) begin : g_lane
    msd_adc_deser #(
      .AdcBits(AdcBits)
    ) u_deser (
      .clk  (clk),
      .rst  (rst),
      .cap  (cap),
      .sdata(SData[i]),
      .word (words[i])
    );
  end

endmodule

// File: tb/tb_msd_readout_seq.sv
// Scoreboard bench for msd_readout_seq: 4 channels, 2 ADC lanes, 12-bit conversions,
// slwEn every 4th clock, behavioural ADC returning a fixed word per lane.
module tb_msd_readout_seq;

  localparam int NA        = 2;
  localparam int NC        = 4;
  localparam int NB        = 12;
  localparam int CONV_CLKS = 2 * NB * 4;
`ifdef MSD_TESTON_EN
  localparam logic TON_EXP = 1'b1;
`else
  localparam logic TON_EXP = 1'b0;
`endif

  logic          clk;
  logic          rst, en, start, slwEn;
  logic [2:0]    gain;
`ifdef MSD_TESTON_EN
  logic          testMode;
`endif
  logic          busy, error, reset, compl;
  logic          G0, G1, G2, Holdn, DRst, ShiftInn, Clk, TestOn;
  logic          ShiftOutn, SClk, CsN;
  logic [NA-1:0] SData;

  msd_readout_seq_if #(.TotalAdcs(NA), .AdcBits(NB)) fif ();

  msd_readout_seq #(
    .TotalAdcs(NA), .Channels(NC), .AdcBits(NB), .HoldTicks(4), .SettleTicks(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .slwEn(slwEn), .gain(gain),
`ifdef MSD_TESTON_EN
    .testMode(testMode),
`endif
    .busy(busy), .error(error), .reset(reset), .compl(compl),
    .G0(G0), .G1(G1), .G2(G2), .Holdn(Holdn), .DRst(DRst), .ShiftInn(ShiftInn),
    .Clk(Clk), .TestOn(TestOn), .ShiftOutn(ShiftOutn), .SClk(SClk), .CsN(CsN),
    .SData(SData), .fifo(fif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int              n_chk, n_err;
  logic [2*NB-1:0] sb[$];
  logic [NB-1:0]   pat[NA];
  int              fallcnt, csn_low, phase;
  int              wr_cnt, clkp_cnt, drst_cnt, compl_cnt;
  logic            sclk_prev, clk_prev, drst_prev, compl_prev;
  bit              abort_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: sample outputs at negedge, run scoreboard/monitors, drive ADC and slwEn.
  task automatic step();
    int bi;
    @(negedge clk);
    if (fif.fifoWr != '0) begin
      wr_cnt++;
      if (sb.size() == 0) chk("wr_unexpected", 32'(fif.fifoWr), 32'd0);
      else begin
        chk("fifo_data", 32'({fif.fifoData[1], fif.fifoData[0]}), 32'(sb.pop_front()));
        chk("fifo_wr", 32'(fif.fifoWr), 32'd3);
      end
    end
    if (CsN) begin
      if (csn_low != 0 && !abort_exp) chk("csn_low_clks", csn_low, CONV_CLKS);
      csn_low = 0;
      fallcnt = 0;
    end else begin
      csn_low++;
      if (sclk_prev && !SClk) fallcnt++;
    end
    sclk_prev = SClk;
    if (Clk && !clk_prev) clkp_cnt++;
    clk_prev = Clk;
    if (DRst && !drst_prev) drst_cnt++;
    drst_prev = DRst;
    if (compl_prev) chk("busy_fall", 32'(busy), 32'd0);
    if (compl) begin
      compl_cnt++;
      chk("busy_at_compl", 32'(busy), 32'd1);
    end
    compl_prev = compl;
    for (int i = 0; i < NA; i++) begin
      bi = NB - 1 - fallcnt;
      SData[i] = (bi >= 0) ? pat[i][bi] : 1'b0;
    end
    phase = (phase + 1) % 4;
    slwEn = (phase == 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_compl(input int budget);
    int c0;
    c0 = compl_cnt;
    for (int i = 0; i < budget && compl_cnt == c0; i++) step();
    chk("compl_seen", compl_cnt - c0, 1);
  endtask

  task automatic full_readout(input logic [NB-1:0] p0, input logic [NB-1:0] p1, input logic [2:0] g);
    int w0, k0, d0, c0;
    pat[0] = p0;
    pat[1] = p1;
    gain   = g;
`ifdef MSD_TESTON_EN
    testMode = 1'b1;
`endif
    for (int c = 0; c < NC; c++) sb.push_back({p1, p0});
    w0 = wr_cnt; k0 = clkp_cnt; d0 = drst_cnt; c0 = compl_cnt;
    pulse_start();
    gain = ~g;
`ifdef MSD_TESTON_EN
    testMode = 1'b0;
`endif
    repeat (20) step();
    chk("gain_pins", 32'({G2, G1, G0}), 32'(g));
    chk("teston_run", 32'(TestOn), 32'(TON_EXP));
    chk("holdn_low", 32'(Holdn), 32'd0);
    chk("busy_run", 32'(busy), 32'd1);
    wait_compl(6000);
    step();
    chk("writes", wr_cnt - w0, NC);
    chk("fe_clk_pulses", clkp_cnt - k0, NC);
    chk("drst_pulses", drst_cnt - d0, 1);
    chk("compl_pulses", compl_cnt - c0, 1);
    chk("sb_empty", sb.size(), 0);
    chk("error_clean", 32'(error), 32'd0);
    chk("teston_idle", 32'(TestOn), 32'd0);
  endtask

  initial begin
    int   w0, d0, c0;
    logic seen;
    n_chk = 0; n_err = 0;
    fallcnt = 0; csn_low = 0; phase = 0;
    wr_cnt = 0; clkp_cnt = 0; drst_cnt = 0; compl_cnt = 0;
    sclk_prev = 1'b1; clk_prev = 1'b0; drst_prev = 1'b0; compl_prev = 1'b0;
    abort_exp = 1'b0;
    rst = 1'b0; en = 1'b0; start = 1'b0; slwEn = 1'b0; gain = 3'b000;
`ifdef MSD_TESTON_EN
    testMode = 1'b0;
`endif
    ShiftOutn = 1'b1; SData = '0; fif.fifoFull = '0;
    pat[0] = '0; pat[1] = '0;

    // Reset state, then 20 idle cycles.
    repeat (5) step();
    chk("reset_pins", 32'({busy, error, reset, compl, Holdn, DRst, ShiftInn, Clk, TestOn,
                           G2, G1, G0, SClk, CsN}), 32'b00001010000011);
    rst = 1'b1;
    repeat (20) step();
    chk("idle_pins", 32'({busy, error, reset, compl, Holdn, DRst, ShiftInn, Clk, TestOn,
                          G2, G1, G0, SClk, CsN}), 32'b00001010000011);
    chk("idle_fifo_data", 32'({fif.fifoData[1], fif.fifoData[0]}), 32'd0);
    chk("idle_no_writes", wr_cnt, 0);

    // Normal readouts with distinct ADC patterns and gains.
    en = 1'b1;
    full_readout(12'hA5A, 12'h3C3, 3'b101);
    full_readout(12'hFFF, 12'h000, 3'b010);

    // FIFO full on the 3rd write: abort with error, then re-arm via start.
    pat[0] = 12'hA5A; pat[1] = 12'h3C3;
    sb.push_back({12'h3C3, 12'hA5A});
    sb.push_back({12'h3C3, 12'hA5A});
    w0 = wr_cnt; d0 = drst_cnt; c0 = compl_cnt;
    pulse_start();
    for (int i = 0; i < 3000 && (wr_cnt - w0) < 2; i++) step();
    chk("pre_full_writes", wr_cnt - w0, 2);
    fif.fifoFull = 2'b10;
    wait_compl(6000);
    chk("full_writes", wr_cnt - w0, 2);
    chk("full_error", 32'(error), 32'd1);
    chk("full_drst", drst_cnt - d0, 1);
    chk("full_compl", compl_cnt - c0, 1);
    chk("full_sb_empty", sb.size(), 0);
    fif.fifoFull = '0;
    repeat (5) step();
    pulse_start();
    repeat (3) step();
    chk("error_rearm", 32'(error), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin step(); seen = seen | busy; end
    chk("rearm_no_run", 32'(seen), 32'd0);

    // en dropped during the 2nd conversion.
    abort_exp = 1'b1;
    sb.push_back({12'h3C3, 12'hA5A});
    w0 = wr_cnt; c0 = compl_cnt;
    pulse_start();
    for (int i = 0; i < 3000 && (wr_cnt - w0) < 1; i++) step();
    for (int i = 0; i < 2000 && CsN; i++) step();
    chk("conv2_started", 32'(CsN), 32'd0);
    repeat (10) step();
    en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin step(); seen = DRst; end
    chk("drst_after_en_low", 32'(seen), 32'd1);
    chk("csn_abort", 32'(CsN), 32'd1);
    chk("sclk_abort", 32'(SClk), 32'd1);
    chk("feclk_abort", 32'(Clk), 32'd0);
    wait_compl(200);
    repeat (100) step();
    chk("abort_writes", wr_cnt - w0, 1);
    chk("abort_compl", compl_cnt - c0, 1);
    chk("abort_no_error", 32'(error), 32'd0);
    chk("abort_sb_empty", sb.size(), 0);
    abort_exp = 1'b0;

    // start with en=0, then start while busy: exactly one readout.
    seen = 1'b0;
    pulse_start();
    for (int i = 0; i < 40; i++) begin step(); seen = seen | busy; end
    chk("start_en_low_ignored", 32'(seen), 32'd0);
    en = 1'b1;
    pat[0] = 12'h123; pat[1] = 12'hEDC;
    for (int c = 0; c < NC; c++) sb.push_back({12'hEDC, 12'h123});
    w0 = wr_cnt; c0 = compl_cnt;
    pulse_start();
    repeat (200) step();
    pulse_start();
    wait_compl(6000);
    repeat (300) step();
    chk("busy_start_compl", compl_cnt - c0, 1);
    chk("busy_start_writes", wr_cnt - w0, NC);
    chk("busy_start_idle", 32'(busy), 32'd0);
    chk("busy_start_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/msd_readout_seq.md
Name: msd_readout_seq

Overview:
- Sequences one complete front-end readout cycle: hold, shift-register scan of Channels channels, one serial ADC conversion per channel on TotalAdcs ADCs in parallel, one FIFO write per ADC per channel.
- Sits between the FE/ADC pins and the per-ADC sample FIFOs.
- Operated by the run-control master through en/start/slwEn and the busy/error/reset/compl status outputs.

Parameters:
- TotalAdcs, 10, number of ADCs sampled in parallel (FIFO lanes)
- Channels, 64, FE channels scanned per readout
- AdcBits, 16, SClk cycles and captured bits per conversion (= FIFO width)
- HoldTicks, 4, slwEn ticks between Holdn fall and shift-in
- SettleTicks, 2, slwEn ticks after each FE Clk pulse before conversion

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- en  in  1  block enable
- start  in  1  single-cycle readout request
- slwEn  in  1  slow-timing tick, one clk wide; all pin-timing steps advance only on ticks
- gain  in  3  gain code, latched on accepted start, drives {G2,G1,G0}
- busy  out  1  sequence in progress
- error  out  1  sticky FIFO-overflow flag
- reset  out  1  high while DRst is asserted
- compl  out  1  one-clk pulse at readout end
- G0, G1, G2  out  1 each  FE gain select
- Holdn, DRst, ShiftInn, Clk, TestOn  out  1 each  FE control
- ShiftOutn  in  1  FE token out (monitor only)
- SClk, CsN  out  1 each  ADC serial clock / chip select
- SData  in  TotalAdcs  ADC serial data, one bit per ADC
- fifoData  out  TotalAdcs x AdcBits  write data per lane
- fifoWr  out  TotalAdcs  write strobe per lane
- fifoFull  in  TotalAdcs  full flag per lane

Behaviour:
- Reset values (rst=0 at clk edge): state IDLE; busy=0, error=0, reset=0, compl=0, Holdn=1, DRst=0, ShiftInn=1, Clk=0, TestOn=0, G*=0, SClk=1, CsN=1, fifoWr=0, fifoData=0, counters=0.
- IDLE: start accepted only when en=1 and error=0. On acceptance latch gain, busy=1 on the next cycle, go to HOLD. start while busy is ignored.
- HOLD: Holdn=0, held until DRST. Wait HoldTicks ticks, then go to SHIFTIN.
- SHIFTIN: ShiftInn=0 for exactly one FE Clk period: Clk high for 1 tick, then low for 1 tick. Then ShiftInn=1 and chan=0. Go to SETTLE.
- FECLK (chan>0): Clk high for 1 tick, then low for 1 tick. Go to SETTLE.
- SETTLE: wait SettleTicks ticks, then go to CONV.
- CONV: CsN=0 on the entry tick. SClk toggles on each subsequent tick, AdcBits full periods.
  - On each tick that drives SClk 1->0, shift SData[i] into lane i's register, MSB first.
  - After the last rising SClk: CsN=1, go to WRITE.
- WRITE: exactly one clk cycle with fifoWr all-ones and fifoData = captured words.
  - If any fifoFull=1 in this cycle: no write, error=1, go to DRST (abort).
  - Else chan++. If chan==Channels go to DRST, else go to FECLK.
- DRST: DRst=1 and reset=1 for 1 tick. Holdn=1 and DRst=0 on the next tick. Then compl=1 for one clk, busy=0, back to IDLE.
  - compl is also pulsed on abort.
- en=0 mid-sequence: on the next tick jump to DRST (CsN=1, SClk=1, Clk=0).
- error clears only on rst=0 or on start accepted while en=1 (re-arm). With error=1 a start clears error and is otherwise ignored.
- Counters: chan width clog2(Channels+1); tick counter width clog2(max(HoldTicks,SettleTicks,2*AdcBits)+1).
- No wrap: chan stops at Channels.
- ShiftOutn is not used for control.

Optional Feature:
- MSD_TESTON_EN defined: adds input testMode (1). testMode is latched on start. TestOn = latched testMode from HOLD through DRST inclusive, 0 otherwise.
- Undefined: no testMode port; TestOn constant 0.

Decomposition:
- Package msd_seq_pkg: state enum (IDLE, HOLD, SHIFTIN, FECLK, SETTLE, CONV, WRITE, DRST) and default parameter constants.
- One sub-module: msd_adc_deser, one per lane via generate. It is an AdcBits shift register with a capture enable and a parallel output.

Test Plan:
- Reset, then idle 20 cycles -> all outputs at reset values, no fifoWr.
- Channels=4, TotalAdcs=2, AdcBits=12, slwEn every 4th clk; ADC0 model returns 0xA5A, ADC1 returns 0x3C3; start -> 4 writes per lane with 0xA5A/0x3C3, CsN low exactly 24 ticks per conversion, 4 Clk pulses, one compl, busy falls the cycle after compl.
- fifoFull[1]=1 at the 3rd WRITE -> only 2 writes per lane, error=1, DRst pulse, compl; a new start clears error, no sequence runs.
- en dropped during the 2nd CONV -> DRst within 1 tick, CsN=1, no further fifoWr, compl=1.
- start pulsed while busy and with en=0 -> ignored; exactly one readout runs.
- gain=3'b101 with MSD_TESTON_EN and testMode=1 -> G2..G0=101 during the sequence, TestOn high HOLD..DRST; without the macro TestOn stays 0.
